// File: rtl/uart_rx_pkg.sv
// Shared constants and state encoding for the UART RX oversampling stage.
package uart_rx_pkg;

  localparam int PRESCALE_W   = 6;
  localparam int PRESCALE_MIN = 6;
  localparam int PRESCALE_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_bit_sync.sv
// Two-flop synchronizer for the serial line. Both flops reset to the
// idle-high line level so a reset never looks like a start bit.
module rx_bit_sync (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic ff1_r;
  logic ff2_r;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ff1_r <= 1'b1;
      ff2_r <= 1'b1;
    end else begin
      ff1_r <= d;
      ff2_r <= ff1_r;
    end
  end

  assign q = ff2_r;

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX data sampler: counts oversampling edges inside each bit, takes
// three samples of the line around mid-bit and majority-votes them.
// Optional build macro RX_SYNC_2FF_EN inserts a two-flop synchronizer on
// RX_IN (two extra cycles of line-to-sample delay).
module uart_rx_data_sampler #(
  parameter int PRESCALE_W   = uart_rx_pkg::PRESCALE_W,
  parameter int PRESCALE_MIN = uart_rx_pkg::PRESCALE_MIN
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  bit_tick
);

  import uart_rx_pkg::*;

  // Legal ratio: too-small values fall back to the default, odd values
  // round down so the mid-bit point is an integer.
  function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] pre);
    logic [PRESCALE_W-1:0] res;
    if (pre < PRESCALE_W'(PRESCALE_MIN)) begin
      res = PRESCALE_W'(PRESCALE_DEF);
    end else begin
      res = {pre[PRESCALE_W-1:1], 1'b0};
    end
    return res;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_e             state_r;
  rx_state_e             state_nxt_s;
  logic [PRESCALE_W-1:0] p_r;
  logic [PRESCALE_W-1:0] p_eff_s;
  logic [PRESCALE_W-1:0] half_s;
  logic [PRESCALE_W-1:0] last_s;
  logic [PRESCALE_W-1:0] cnt_r;
  logic [PRESCALE_W-1:0] cnt_nxt_s;
  logic                  rx_s;
  logic                  s0_r;
  logic                  s1_r;
  logic                  cap0_s;
  logic                  cap1_s;
  logic                  vote_s;
  logic                  tick_nxt_s;
  logic                  bit_r;
  logic                  valid_r;
  logic                  tick_r;

`ifdef RX_SYNC_2FF_EN
  rx_bit_sync u_rx_bit_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (RX_IN),
    .q   (rx_s)
  );
`else
  assign rx_s = RX_IN;
`endif

  // State register: COUNT while the RX FSM holds the enable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state follows the level of the enable.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dat_samp_en) state_nxt_s = ST_COUNT;
        else             state_nxt_s = ST_IDLE;
      end
      ST_COUNT: begin
        if (dat_samp_en) state_nxt_s = ST_COUNT;
        else             state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Edge decode: the first enabled cycle already uses the freshly clamped
  // prescale; afterwards the latched value is used so mid-bit changes
  // on the prescale input cannot disturb the count.
  always_comb begin
    p_eff_s = p_r;
    case (state_r)
      ST_IDLE:  p_eff_s = clamp_prescale(prescale);
      ST_COUNT: p_eff_s = p_r;
      default:  p_eff_s = p_r;
    endcase
    half_s = {1'b0, p_eff_s[PRESCALE_W-1:1]};
    last_s = p_eff_s - PRESCALE_W'(1);
    if (dat_samp_en) begin
      if (cnt_r == last_s) cnt_nxt_s = '0;
      else                 cnt_nxt_s = cnt_r + PRESCALE_W'(1);
    end else begin
      cnt_nxt_s = '0;
    end
    cap0_s     = dat_samp_en && (cnt_r == (half_s - PRESCALE_W'(2)));
    cap1_s     = dat_samp_en && (cnt_r == (half_s - PRESCALE_W'(1)));
    // The third sample is the live line on this edge; it is voted at once.
    vote_s     = dat_samp_en && (cnt_r == half_s);
    tick_nxt_s = dat_samp_en && (cnt_nxt_s == last_s);
  end

  // Latch the oversampling ratio on the first enabled cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_r <= PRESCALE_W'(PRESCALE_DEF);
    end else if ((state_r == ST_IDLE) && dat_samp_en) begin
      p_r <= p_eff_s;
    end
  end

  // Edge counter and registered end-of-bit tick.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  // Capture the two early samples of the current bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_r <= 1'b1;
      s1_r <= 1'b1;
    end else begin
      if (cap0_s) s0_r <= rx_s;
      if (cap1_s) s1_r <= rx_s;
    end
  end

  // Majority vote and its one-cycle valid strobe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_r   <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      valid_r <= vote_s;
      if (vote_s) bit_r <= majority3(s0_r, s1_r, rx_s);
    end
  end

  assign sampled_bit  = bit_r;
  assign sample_valid = valid_r;
  assign edge_cnt     = cnt_r;
  assign bit_tick     = tick_r;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Self-checking bench for uart_rx_data_sampler: a run-length model of the
// sampler checked every cycle, directed literal checks, random stimulus.
module tb_uart_rx_data_sampler;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       dat_samp_en;
  logic [5:0] prescale;
  logic       sampled_bit;
  logic       sample_valid;
  logic [5:0] edge_cnt;
  logic       bit_tick;

`ifdef RX_SYNC_2FF_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  uart_rx_data_sampler dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .dat_samp_en  (dat_samp_en),
    .prescale     (prescale),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .edge_cnt     (edge_cnt),
    .bit_tick     (bit_tick)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model state: length of the current enabled run, its latched ratio,
  // the samples of the current bit and the line delay pipeline.
  int   k;
  int   p_run;
  int   seen [3];
  int   d1, d2;
  int   e_cnt;
  int   e_bit;
  int   e_valid;
  int   e_tick;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp_p(input int pre);
    if (pre < 6) return 8;
    return (pre / 2) * 2;
  endfunction

  task automatic model_reset();
    k = 0; p_run = 8;
    seen[0] = 1; seen[1] = 1; seen[2] = 1;
    d1 = 1; d2 = 1;
    e_cnt = 0; e_bit = 1; e_valid = 0; e_tick = 0;
  endtask

  // Apply one cycle of inputs, advance the model, wait past the edge.
  task automatic step(input bit en, input bit rx, input int pre);
    int seen_now;
    int pos;
    dat_samp_en = en;
    RX_IN       = rx;
    prescale    = 6'(pre);
    if (SYNC) begin
      seen_now = d2; d2 = d1; d1 = int'(rx);
    end else begin
      seen_now = int'(rx);
    end
    if (en) begin
      if (k == 0) p_run = clamp_p(pre);
      pos = k % p_run;
      if (pos == p_run/2 - 2) seen[0] = seen_now;
      if (pos == p_run/2 - 1) seen[1] = seen_now;
      if (pos == p_run/2)     seen[2] = seen_now;
      e_valid = (pos == p_run/2) ? 1 : 0;
      if (pos == p_run/2) e_bit = ((seen[0] + seen[1] + seen[2]) >= 2) ? 1 : 0;
      k++;
      e_cnt = k % p_run;
      e_tick = (e_cnt == p_run - 1) ? 1 : 0;
    end else begin
      k = 0; e_valid = 0; e_cnt = 0; e_tick = 0;
    end
    @(posedge CLK);
    #2;
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic reset_pulse();
    RST = 1'b0;
    #1;
    chk("async_rst_bit",   sampled_bit,  1);
    chk("async_rst_valid", sample_valid, 0);
    chk("async_rst_cnt",   edge_cnt,     0);
    chk("async_rst_tick",  bit_tick,     0);
    model_reset();
    RST = 1'b1;
    #1;
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(posedge CLK) begin
    #1;
    if (cmp_en) begin
      chk("edge_cnt",     edge_cnt,     e_cnt);
      chk("bit_tick",     bit_tick,     e_tick);
      chk("sample_valid", sample_valid, e_valid);
      chk("sampled_bit",  sampled_bit,  e_bit);
    end
  end

  initial begin
    bit en_r;
    bit rx_r;
    int pre_r;
    int rem;
    RST = 1'b0; RX_IN = 1'b0; dat_samp_en = 1'b0; prescale = 6'd8;
    model_reset();
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_bit",   sampled_bit,  1);
    chk("rst_valid", sample_valid, 0);
    chk("rst_cnt",   edge_cnt,     0);
    chk("rst_tick",  bit_tick,     0);
    RST = 1'b1;
    cmp_en = 1'b1;
    step(1'b0, 1'b1, 8);
    step(1'b0, 1'b1, 8);

    // Normal bit, P=8, line low.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8);
      if (i == 4) begin
        chk("d1_cnt5", edge_cnt, 5);
        chk("d1_valid", sample_valid, 1);
        chk("d1_bit0", sampled_bit, 0);
      end
      if (i == 5) chk("d1_valid_once", sample_valid, 0);
      if (i == 6) begin
        chk("d1_cnt7", edge_cnt, 7);
        chk("d1_tick", bit_tick, 1);
      end
      if (i == 7) chk("d1_wrap", edge_cnt, 0);
    end
    step(1'b0, 1'b1, 8);

    // Glitch rejection, P=16, single low at edge 7.
    for (int j = 0; j < 16; j++) begin
      step(1'b1, (j == 7) ? 1'b0 : 1'b1, 16);
      if (j == 8) begin
        chk("d2_cnt9", edge_cnt, 9);
        chk("d2_valid", sample_valid, 1);
        chk("d2_bit1", sampled_bit, 1);
      end
    end
    step(1'b0, 1'b1, 16);

    // Clamp of 4 to 8, and prescale change ignored while enabled.
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 1'b0, (j < 8) ? 4 : 32);
      if (j == 6) chk("d3_tick_p8", bit_tick, 1);
      if (j == 7) chk("d3_wrap_p8", edge_cnt, 0);
      if (j == 13) chk("d3_locked", edge_cnt, 6);
    end
    step(1'b0, 1'b0, 17);
    // Odd 17 rounds down to 16.
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 1'b0, 17);
      if (j == 14) chk("d3_tick_p16", bit_tick, 1);
      if (j == 15) chk("d3_wrap_p16", edge_cnt, 0);
    end
    step(1'b0, 1'b0, 8);

    // Enable dropped at edge 3: no vote, count back to 0.
    for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 8);
    chk("d4_cnt3", edge_cnt, 3);
    step(1'b0, 1'b1, 8);
    chk("d4_cnt0", edge_cnt, 0);
    chk("d4_novalid", sample_valid, 0);
    chk("d4_bit_hold", sampled_bit, 0);
    step(1'b0, 1'b1, 8);
    chk("d4_novalid2", sample_valid, 0);

    // Line low only at edges 1..2: visible to the vote only via the synchronizer delay.
    for (int j = 0; j < 8; j++) begin
      step(1'b1, (j == 1 || j == 2) ? 1'b0 : 1'b1, 8);
      if (j == 4) begin
        chk("d5_valid", sample_valid, 1);
`ifdef RX_SYNC_2FF_EN
        chk("d5_bit_sync", sampled_bit, 0);
`else
        chk("d5_bit_direct", sampled_bit, 1);
`endif
      end
    end
    step(1'b0, 1'b0, 8);

    // Reset in the middle of a bit.
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 8);
    reset_pulse();
    step(1'b0, 1'b1, 8);

    // Random traffic with random enable runs, prescale churn and resets.
    en_r = 1'b0; rx_r = 1'b1; pre_r = 8; rem = 2;
    for (int c = 0; c < 4000; c++) begin
      if (rem == 0) begin
        en_r = ~en_r;
        rem  = en_r ? int'($urandom_range(1, 90)) : int'($urandom_range(1, 6));
      end
      rem--;
      if ($urandom_range(0, 3) == 0) rx_r = ~rx_r;
      if ($urandom_range(0, 7) == 0) pre_r = int'($urandom_range(0, 63));
      step(en_r, rx_r, pre_r);
      if ($urandom_range(0, 599) == 0) reset_pulse();
    end

    step(1'b0, 1'b1, 8);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
